// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide: radix-2 shift-add and restoring divide over magnitudes.
// Result lands WIDTH+1 cycles after start is accepted; busy stalls the datapath, start while busy is dropped.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;

  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;
  // acc: product high half / partial remainder; lsr: multiplier / dividend-then-quotient
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lsr;
  logic [WIDTH-1:0] opb;

  logic             sgn_op;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN:     if (cnt == CNTW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn_op   = ~op[0];
    a_mag    = (sgn_op && srca[WIDTH-1]) ? -srca : srca;
    b_mag    = (sgn_op && srcb[WIDTH-1]) ? -srcb : srcb;

    mul_sum  = {1'b0, acc} + {1'b0, (lsr[0] ? opb : {WIDTH{1'b0}})};

    // acc stays below a nonzero divisor, so the shifted value never exceeds 2*divisor
    div_sh   = {acc, lsr[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opb});
    div_diff = div_sh[WIDTH-1:0] - opb;

    prod     = (neg_a ^ neg_b) ? -{acc, lsr} : {acc, lsr};

    if (!is_div) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else if (b_zero) begin
      // with a zero divisor the remainder path reassembles the dividend, sign restored below
      res_hi = neg_a ? -acc : acc;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = neg_a ? -acc : acc;
      res_lo = (neg_a ^ neg_b) ? -lsr : lsr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      b_zero      <= 1'b0;
      acc         <= '0;
      lsr         <= '0;
      opb         <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_a  <= sgn_op & srca[WIDTH-1];
            neg_b  <= sgn_op & srcb[WIDTH-1];
            b_zero <= (srcb == '0);
            cnt    <= CNTW'(WIDTH);
            acc    <= '0;
            lsr    <= a_mag;
            opb    <= b_mag;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            lsr <= {lsr[WIDTH-2:0], div_ge};
          end else begin
            {acc, lsr} <= {mul_sum, lsr[WIDTH-1:1]};
          end
        end
        FIN: begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          div_by_zero <= is_div & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed checks of muldiv_unit (WIDTH=32 and WIDTH=8) against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  logic          start, hi_we, lo_we, busy, done, div_by_zero;
  logic [1:0]    op;
  logic [W-1:0]  srca, srcb, wdata, hi, lo;

  logic          start8, hi_we8, lo_we8, busy8, done8, dz8;
  logic [1:0]    op8;
  logic [7:0]    srca8, srcb8, wdata8, hi8, lo8;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .srca(srca8), .srcb(srcb8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MIPS HI/LO semantics in plain integer arithmetic for operand width w (<= 32)
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l, output logic dz);
    longint mask, ua, ub, sa, sb, q, r;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = ua[w-1] ? ua - mask - 1 : ua;
    sb = ub[w-1] ? ub - mask - 1 : ub;
    dz = 1'b0;
    if (!o[1]) begin
      p = o[0] ? ua * ub : sa * sb;
      h = 32'((p >> w) & 64'(mask));
      l = 32'(p & 64'(mask));
    end else if (ub == 0) begin
      l  = 32'(mask);
      h  = 32'(ua);
      dz = 1'b1;
    end else begin
      if (o[0]) begin q = ua / ub; r = ua % ub; end
      else      begin q = sa / sb; r = sa % sb; end
      l = 32'(q & mask);
      h = 32'(r & mask);
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(15));
      4:       return 32'hFFFFFFFF - 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_k, input logic inj_start, input logic inj_lo,
                        input logic we_start);
    logic [31:0] eh, el;
    logic        edz;
    int          k, nbusy;
    model(W, o, a, b, eh, el, edz);
    start = 1'b1; op = o; srca = a; srcb = b;
    if (we_start) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (we_start) begin m_hi = wdata; m_lo = wdata; end
    k = 0; nbusy = 0;
    while (!done && k <= 2 * W) begin
      if (busy) nbusy++;
      if (k == W / 2) begin
        chk("hold_hi", hi, m_hi);
        chk("hold_lo", lo, m_lo);
      end
      start = 1'b0; lo_we = 1'b0;
      if (k == inj_k) begin
        start = inj_start; op = 2'($urandom); srca = $urandom; srcb = $urandom;
        lo_we = inj_lo; wdata = 32'h1234;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; lo_we = 1'b0;
    chk("latency", k, W + 1);
    chk("busy_cycles", nbusy, W + 1);
    chk("busy_at_done", busy, 0);
    chk("done", done, 1);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_by_zero", div_by_zero, edz);
    m_hi = eh; m_lo = el;
  endtask

  task automatic post_check();
    @(negedge clk);
    chk("done_cleared", done, 0);
    chk("dz_cleared", div_by_zero, 0);
    chk("busy_idle", busy, 0);
    chk("hi_stable", hi, m_hi);
    chk("lo_stable", lo, m_lo);
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [31:0] eh, el;
    logic        edz;
    int          k;
    model(8, o, {24'd0, a}, {24'd0, b}, eh, el, edz);
    start8 = 1'b1; op8 = o; srca8 = a; srcb8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    while (!done8 && k <= 20) begin
      @(negedge clk);
      k++;
    end
    chk("lat8", k, 9);
    chk("hi8", hi8, eh[7:0]);
    chk("lo8", lo8, el[7:0]);
    chk("dz8", dz8, edz);
    @(negedge clk);
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    start = 0; op = 0; srca = 0; srcb = 0; hi_we = 0; lo_we = 0; wdata = 0;
    start8 = 0; op8 = 0; srca8 = 0; srcb8 = 0; hi_we8 = 0; lo_we8 = 0; wdata8 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy8", busy8, 0);
    rst = 1'b0;
    m_hi = 0; m_lo = 0;

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'hABCD);
    chk("mthi_lo_kept", lo, 0);
    m_hi = 32'hABCD;

    run8(2'b00, 8'h80, 8'h80);
    chk("mult8_hi_lit", hi8, 8'h40);
    run8(2'b11, 8'hFF, 8'h10);
    chk("divu8_lo_lit", lo8, 8'h0F);
    run8(2'b10, 8'h80, 8'hFF);
    run8(2'b10, 8'hF3, 8'h00);
    for (int i = 0; i < 16; i++) run8(2'($urandom), 8'($urandom), 8'($urandom_range(3) == 0 ? 0 : $urandom));

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, 0, 0);
    chk("multu_ff_hi_lit", hi, 32'hFFFFFFFE);
    chk("multu_ff_lo_lit", lo, 32'h00000001);
    post_check();
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1, 0, 0, 0);
    chk("mult_lo_lit", lo, 32'hFFFFFFEB);
    post_check();
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1, 0, 0, 0);
    chk("div_hi_lit", hi, 32'hFFFFFFFF);
    post_check();
    run_op(2'b11, 32'd100, 32'd0, -1, 0, 0, 0);
    chk("divu0_hi_lit", hi, 32'h64);
    post_check();
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, 0, 0, 0);
    post_check();
    run_op(2'b10, 32'h80000005, 32'd0, -1, 0, 0, 0);
    post_check();
    run_op(2'b01, 32'd6, 32'd7, 4, 1, 0, 0);
    chk("ignored_start_lo_lit", lo, 32'd42);
    post_check();
    run_op(2'b00, $urandom, $urandom, 9, 0, 1, 0);
    post_check();
    run_op(2'b10, $urandom, 32'd5, -1, 0, 0, 1);
    run_op(2'b11, $urandom, $urandom_range(1000), -1, 0, 0, 0);
    post_check();

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(), -1, 0, 0, 1'($urandom_range(3) == 0));
      if ($urandom_range(1) == 1) post_check();
    end
    post_check();

    start = 1'b1; op = 2'b10; srca = $urandom; srcb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    chk("idle_after_rst", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
